// File: rtl/rs5_bus_pkg.sv
// ---------------------------------------------------------------------------
// rs5_bus_pkg
//   Types shared by the RS5 Wishbone arbiter and the RS5 bus adapter.
//   arb_state_e : arbiter FSM states (IDLE -> ISSUE -> WAIT -> IDLE)
//   grant_e     : bus owner encoding, also driven out on grant_o
//   wb_req_t    : one Wishbone request as seen by the adapter (default widths)
// ---------------------------------------------------------------------------
package rs5_bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_SEL_W  = BUS_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // Encoding is visible on grant_o: 00 none, 01 instruction, 10 data.
  typedef enum logic [1:0] {
    GNT_NONE  = 2'b00,
    GNT_INSTR = 2'b01,
    GNT_DATA  = 2'b10
  } grant_e;

  typedef struct packed {
    logic                  we;
    logic [BUS_SEL_W-1:0]  sel;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/rs5_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rs5_rr_arbiter2
//   Two-way request picker with a last-grant register.
//   clk, rst_n      : clock, synchronous active-low reset
//   req_i, req_d    : instruction / data port eligible this cycle
//   update          : commit the pick into last-grant (arbiter is idle)
//   gnt_i, gnt_d    : combinational one-hot pick (both 0 when no request)
//   FIXED_PRIO = 1  : data wins every tie; 0: the port not granted last wins.
//   last-grant resets to DATA so the first tie goes to the instruction port.
// ---------------------------------------------------------------------------
module rs5_rr_arbiter2
  import rs5_bus_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic req_d,
  input  logic update,
  output logic gnt_i,
  output logic gnt_d
);

  grant_e last_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (req_i && req_d) begin
      if ((FIXED_PRIO != 0) || (last_q == GNT_INSTR)) gnt_d = 1'b1;
      else                                            gnt_i = 1'b1;
    end else begin
      gnt_i = req_i;
      gnt_d = req_d;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update together at the edge.
    if (!rst_n)                last_q <= GNT_DATA;
    else if (update && gnt_i)  last_q <= GNT_INSTR;
    else if (update && gnt_d)  last_q <= GNT_DATA;
  end

endmodule

// File: rtl/rs5_wb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// rs5_wb_bus_arbiter
//   Shares one pipelined Wishbone master port between the RS5 instruction
//   fetch (i_*) and data (d_*) requesters. One outstanding transaction,
//   every output registered, watchdog errors a hung transaction.
//   clk, rst_n            : core clock, synchronous active-low reset
//   {i,d}_cyc/stb/we/sel/addr/wdata : requester inputs (request = cyc & stb)
//   {i,d}_rdata/ack/err   : requester responses, one-cycle pulses
//   m_cyc/stb/we/sel/addr/wdata     : master Wishbone outputs
//   m_rdata, m_ack        : master responses
//   grant_o               : current owner (00 none, 01 instr, 10 data)
// ---------------------------------------------------------------------------
module rs5_wb_bus_arbiter
  import rs5_bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_cyc,
  input  logic                i_stb,
  input  logic                i_we,
  input  logic [DATA_W/8-1:0] i_sel,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  output logic                i_err,
  input  logic                d_cyc,
  input  logic                d_stb,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_sel,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                d_err,
  output logic                m_cyc,
  output logic                m_stb,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_sel,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ack,
  output logic [1:0]          grant_o
);

  localparam int SEL_W = DATA_W / 8;
  // Counter must hold TIMEOUT itself; keep one bit when the watchdog is off.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W:0]   TIMEOUT_V = (CNT_W + 1)'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  arb_state_e       state_q, state_d;
  grant_e           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;

  logic              m_cyc_d, m_stb_d, m_we_d;
  logic [SEL_W-1:0]  m_sel_d;
  logic [ADDR_W-1:0] m_addr_d;
  logic [DATA_W-1:0] m_wdata_d;
  logic              i_ack_d, i_err_d, d_ack_d, d_err_d;
  logic [DATA_W-1:0] i_rdata_d, d_rdata_d;

  logic elig_i, elig_d, pick_i, pick_d;
  logic [CNT_W:0] cnt_inc;
  logic timeout_hit, owner_cyc, dropped;

  // A port whose ack/err is high this cycle has not yet seen its own
  // completion, so its still-raised stb must not start a new transaction.
  assign elig_i = i_cyc & i_stb & ~i_ack & ~i_err;
  assign elig_d = d_cyc & d_stb & ~d_ack & ~d_err;

  rs5_rr_arbiter2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (elig_i),
    .req_d  (elig_d),
    .update (state_q == IDLE),
    .gnt_i  (pick_i),
    .gnt_d  (pick_d)
  );

  // cnt_q counts completed cycles since ISSUE; the edge that makes it reach
  // TIMEOUT raises err, so err appears TIMEOUT cycles after the ISSUE cycle.
  assign cnt_inc     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign timeout_hit = (TIMEOUT > 0) && (cnt_inc >= TIMEOUT_V);
  assign owner_cyc   = (owner_q == GNT_INSTR) ? i_cyc : d_cyc;
  // Once the owner abandons its cycle, the response is swallowed even if it
  // raises cyc again before the bus completes.
  assign dropped     = abort_q | ~owner_cyc;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    m_cyc_d   = m_cyc;
    m_stb_d   = 1'b0;
    m_we_d    = m_we;
    m_sel_d   = m_sel;
    m_addr_d  = m_addr;
    m_wdata_d = m_wdata;
    i_ack_d   = 1'b0;
    i_err_d   = 1'b0;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    i_rdata_d = '0;
    d_rdata_d = '0;

    case (state_q)
      IDLE: begin
        m_cyc_d = 1'b0;
        owner_d = GNT_NONE;
        if (pick_i || pick_d) begin
          m_cyc_d   = 1'b1;
          m_stb_d   = 1'b1;
          m_we_d    = pick_d ? d_we    : i_we;
          m_sel_d   = pick_d ? d_sel   : i_sel;
          m_addr_d  = pick_d ? d_addr  : i_addr;
          m_wdata_d = pick_d ? d_wdata : i_wdata;
          owner_d   = pick_d ? GNT_DATA : GNT_INSTR;
          cnt_d     = '0;
          abort_d   = 1'b0;
          state_d   = ISSUE;
        end
      end

      ISSUE, WAIT: begin
        abort_d = dropped;
        if (m_ack || timeout_hit) begin
          m_cyc_d = 1'b0;
          owner_d = GNT_NONE;
          cnt_d   = '0;
          state_d = IDLE;
          if (!dropped) begin
            if (owner_q == GNT_INSTR) begin
              i_ack_d   = m_ack;
              i_err_d   = ~m_ack;
              i_rdata_d = m_ack ? m_rdata : '0;
            end else begin
              d_ack_d   = m_ack;
              d_err_d   = ~m_ack;
              d_rdata_d = m_ack ? m_rdata : '0;
            end
          end
        end else begin
          m_cyc_d = 1'b1;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_inc[CNT_W-1:0];
          state_d = WAIT;
        end
      end

      default: begin
        m_cyc_d = 1'b0;
        owner_d = GNT_NONE;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too, because every output must read 0 straight out of reset.
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= GNT_NONE;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      m_cyc   <= 1'b0;
      m_stb   <= 1'b0;
      m_we    <= 1'b0;
      m_sel   <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_ack   <= 1'b0;
      i_err   <= 1'b0;
      i_rdata <= '0;
      d_ack   <= 1'b0;
      d_err   <= 1'b0;
      d_rdata <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      m_cyc   <= m_cyc_d;
      m_stb   <= m_stb_d;
      m_we    <= m_we_d;
      m_sel   <= m_sel_d;
      m_addr  <= m_addr_d;
      m_wdata <= m_wdata_d;
      i_ack   <= i_ack_d;
      i_err   <= i_err_d;
      i_rdata <= i_rdata_d;
      d_ack   <= d_ack_d;
      d_err   <= d_err_d;
      d_rdata <= d_rdata_d;
    end
  end

  assign grant_o = owner_q;

endmodule

// File: tb/tb_rs5_wb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rs5_wb_bus_arbiter
//   Directed bench. Two arbiters share every input: dut_a is round-robin,
//   dut_b is fixed-priority; both use an 8-cycle watchdog. Inputs change and
//   outputs are checked 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_rs5_wb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_cyc, i_stb, i_we;
  logic [3:0]  i_sel;
  logic [31:0] i_addr, i_wdata;
  logic        d_cyc, d_stb, d_we;
  logic [3:0]  d_sel;
  logic [31:0] d_addr, d_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;

  logic [31:0] a_i_rdata, a_d_rdata, a_m_addr, a_m_wdata;
  logic        a_i_ack, a_i_err, a_d_ack, a_d_err, a_m_cyc, a_m_stb, a_m_we;
  logic [3:0]  a_m_sel;
  logic [1:0]  a_grant;

  logic [31:0] b_i_rdata, b_d_rdata, b_m_addr, b_m_wdata;
  logic        b_i_ack, b_i_err, b_d_ack, b_d_err, b_m_cyc, b_m_stb, b_m_we;
  logic [3:0]  b_m_sel;
  logic [1:0]  b_grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rs5_wb_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .TIMEOUT(8)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_sel(i_sel),
    .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(a_i_rdata), .i_ack(a_i_ack), .i_err(a_i_err),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_sel(d_sel),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(a_d_rdata), .d_ack(a_d_ack), .d_err(a_d_err),
    .m_cyc(a_m_cyc), .m_stb(a_m_stb), .m_we(a_m_we), .m_sel(a_m_sel),
    .m_addr(a_m_addr), .m_wdata(a_m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .grant_o(a_grant)
  );

  rs5_wb_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .TIMEOUT(8)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_sel(i_sel),
    .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(b_i_rdata), .i_ack(b_i_ack), .i_err(b_i_err),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_sel(d_sel),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(b_d_rdata), .d_ack(b_d_ack), .d_err(b_d_err),
    .m_cyc(b_m_cyc), .m_stb(b_m_stb), .m_we(b_m_we), .m_sel(b_m_sel),
    .m_addr(b_m_addr), .m_wdata(b_m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .grant_o(b_grant)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_cyc = 1'b0; i_stb = 1'b0;
    d_cyc = 1'b0; d_stb = 1'b0;
    m_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "simulation time limit");
  end

  initial begin
    idle_inputs();
    i_we = 1'b0; i_sel = 4'hF; i_addr = '0; i_wdata = '0;
    d_we = 1'b0; d_sel = 4'hF; d_addr = '0; d_wdata = '0;
    m_rdata = '0;
    rst_n = 1'b0;
    step();
    step();

    // Reset state
    check("rst_m_cyc",  32'(a_m_cyc), 32'd0);
    check("rst_m_stb",  32'(a_m_stb), 32'd0);
    check("rst_grant",  32'(a_grant), 32'd0);
    check("rst_i_ack",  32'(a_i_ack), 32'd0);
    check("rst_d_err",  32'(a_d_err), 32'd0);
    check("rst_m_addr", a_m_addr,     32'd0);
    rst_n = 1'b1;

    // 1: instruction read, m_ack two cycles after m_stb
    i_cyc = 1'b1; i_stb = 1'b1; i_addr = 32'h100;
    step(); // cycle 1
    check("t1_m_stb",  32'(a_m_stb), 32'd1);
    check("t1_m_cyc",  32'(a_m_cyc), 32'd1);
    check("t1_m_addr", a_m_addr,     32'h100);
    check("t1_grant",  32'(a_grant), 32'd1);
    step(); // cycle 2
    check("t1_wait_stb", 32'(a_m_stb), 32'd0);
    check("t1_wait_cyc", 32'(a_m_cyc), 32'd1);
    step(); // cycle 3
    check("t1_no_early_ack", 32'(a_i_ack), 32'd0);
    m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
    step(); // cycle 4
    check("t1_i_ack",   32'(a_i_ack), 32'd1);
    check("t1_i_rdata", a_i_rdata,    32'hDEADBEEF);
    check("t1_d_ack",   32'(a_d_ack), 32'd0);
    check("t1_d_rdata", a_d_rdata,    32'd0);
    check("t1_m_cyc0",  32'(a_m_cyc), 32'd0);
    check("t1_grant0",  32'(a_grant), 32'd0);
    m_ack = 1'b0; m_rdata = '0; i_cyc = 1'b0; i_stb = 1'b0;
    step(); // cycle 5
    check("t1_ack_pulse", 32'(a_i_ack), 32'd0);
    check("t1_idle_cyc",  32'(a_m_cyc), 32'd0);

    // 2: both requesting continuously, immediate acks
    do_reset();
    i_cyc = 1'b1; i_stb = 1'b1; d_cyc = 1'b1; d_stb = 1'b1;
    m_ack = 1'b1; m_rdata = 32'hA5A50000;
    step();
    for (int t = 0; t < 4; t++) begin
      check($sformatf("t2_a_grant_%0d", t), 32'(a_grant), (t % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("t2_b_grant_%0d", t), 32'(b_grant), (t % 2 == 0) ? 32'd2 : 32'd1);
      check($sformatf("t2_a_stb_%0d", t),   32'(a_m_stb), 32'd1);
      step();
      check($sformatf("t2_a_i_ack_%0d", t), 32'(a_i_ack), (t % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("t2_a_d_ack_%0d", t), 32'(a_d_ack), (t % 2 == 0) ? 32'd0 : 32'd1);
      check($sformatf("t2_a_rdata_%0d", t), (t % 2 == 0) ? a_i_rdata : a_d_rdata, 32'hA5A50000);
      check($sformatf("t2_b_d_ack_%0d", t), 32'(b_d_ack), (t % 2 == 0) ? 32'd1 : 32'd0);
      if (t == 3) idle_inputs();
      step();
    end

    // 2/3: simultaneous ties from idle
    for (int r = 0; r < 3; r++) begin
      i_cyc = 1'b1; i_stb = 1'b1; d_cyc = 1'b1; d_stb = 1'b1; m_ack = 1'b1;
      step();
      check($sformatf("tie_a_grant_%0d", r), 32'(a_grant), (r % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("tie_b_grant_%0d", r), 32'(b_grant), 32'd2);
      step();
      check($sformatf("tie_b_d_ack_%0d", r), 32'(b_d_ack), 32'd1);
      check($sformatf("tie_b_i_ack_%0d", r), 32'(b_i_ack), 32'd0);
      idle_inputs();
      step();
    end
    i_cyc = 1'b1; i_stb = 1'b1; m_ack = 1'b1;
    step();
    check("t3_b_instr_alone", 32'(b_grant), 32'd1);
    step();
    check("t3_b_i_ack", 32'(b_i_ack), 32'd1);
    idle_inputs();
    step();

    // 4: data write
    d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_sel = 4'b0011;
    d_wdata = 32'h12345678; d_addr = 32'h200;
    step();
    check("t4_m_we",    32'(a_m_we),  32'd1);
    check("t4_m_sel",   32'(a_m_sel), 32'h3);
    check("t4_m_wdata", a_m_wdata,    32'h12345678);
    check("t4_m_addr",  a_m_addr,     32'h200);
    check("t4_grant",   32'(a_grant), 32'd2);
    step();
    check("t4_wait_stb",  32'(a_m_stb), 32'd0);
    check("t4_wait_we",   32'(a_m_we),  32'd1);
    check("t4_wait_data", a_m_wdata,    32'h12345678);
    m_ack = 1'b1; m_rdata = 32'h00000055;
    step();
    check("t4_d_ack",   32'(a_d_ack), 32'd1);
    check("t4_d_rdata", a_d_rdata,    32'h55);
    check("t4_i_ack",   32'(a_i_ack), 32'd0);
    check("t4_m_cyc0",  32'(a_m_cyc), 32'd0);
    idle_inputs(); d_we = 1'b0; d_sel = 4'hF;
    step();
    check("t4_ack_pulse", 32'(a_d_ack), 32'd0);

    // 5: watchdog, m_ack never arrives
    d_cyc = 1'b1; d_stb = 1'b1; d_addr = 32'h300;
    step(); // ISSUE cycle
    check("t5_m_stb", 32'(a_m_stb), 32'd1);
    for (int n = 2; n <= 8; n++) begin
      step();
      check($sformatf("t5_no_err_%0d", n), 32'(a_d_err), 32'd0);
      check($sformatf("t5_cyc_%0d", n),    32'(a_m_cyc), 32'd1);
    end
    step(); // 8 cycles after ISSUE
    check("t5_d_err",   32'(a_d_err), 32'd1);
    check("t5_b_d_err", 32'(b_d_err), 32'd1);
    check("t5_d_ack",   32'(a_d_ack), 32'd0);
    check("t5_d_rdata", a_d_rdata,    32'd0);
    check("t5_m_cyc0",  32'(a_m_cyc), 32'd0);
    check("t5_grant0",  32'(a_grant), 32'd0);
    idle_inputs();
    step();
    check("t5_err_pulse", 32'(a_d_err), 32'd0);
    i_cyc = 1'b1; i_stb = 1'b1; i_addr = 32'h400;
    step();
    check("t5_next_stb",   32'(a_m_stb), 32'd1);
    check("t5_next_grant", 32'(a_grant), 32'd1);
    m_ack = 1'b1; m_rdata = 32'h0000CAFE;
    step();
    check("t5_next_ack",   32'(a_i_ack), 32'd1);
    check("t5_next_rdata", a_i_rdata,    32'h0000CAFE);
    idle_inputs();
    step();

    // Requester abandons its cycle mid-transaction
    i_cyc = 1'b1; i_stb = 1'b1;
    step(); // ISSUE
    step(); // WAIT
    i_cyc = 1'b0; i_stb = 1'b0;
    step();
    check("drop_still_cyc", 32'(a_m_cyc), 32'd1);
    m_ack = 1'b1;
    step();
    check("drop_no_ack", 32'(a_i_ack), 32'd0);
    check("drop_m_cyc0", 32'(a_m_cyc), 32'd0);
    idle_inputs();
    step();

    // 6: reset while in WAIT, late m_ack, first tie after reset
    d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_sel = 4'b1100; d_addr = 32'h500;
    step(); // ISSUE
    step(); // WAIT
    check("t6_in_wait", 32'(a_m_cyc), 32'd1);
    rst_n = 1'b0;
    idle_inputs();
    step();
    check("t6_m_cyc",  32'(a_m_cyc), 32'd0);
    check("t6_m_stb",  32'(a_m_stb), 32'd0);
    check("t6_m_we",   32'(a_m_we),  32'd0);
    check("t6_m_sel",  32'(a_m_sel), 32'd0);
    check("t6_m_addr", a_m_addr,     32'd0);
    check("t6_grant",  32'(a_grant), 32'd0);
    rst_n = 1'b1; m_ack = 1'b1;
    step();
    check("t6_late_d_ack", 32'(a_d_ack), 32'd0);
    check("t6_late_i_ack", 32'(a_i_ack), 32'd0);
    check("t6_late_cyc",   32'(a_m_cyc), 32'd0);
    m_ack = 1'b0; d_we = 1'b0; d_sel = 4'hF;
    i_cyc = 1'b1; i_stb = 1'b1; d_cyc = 1'b1; d_stb = 1'b1;
    step();
    check("t6_a_first_tie", 32'(a_grant), 32'd1);
    check("t6_b_first_tie", 32'(b_grant), 32'd2);
    m_ack = 1'b1;
    step();
    check("t6_a_i_ack", 32'(a_i_ack), 32'd1);
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
